hold_detect_multi: RTL and testbench

//   Multi-channel long-press / hold detector with built-in clock prescaler.
//   A free-running prescaler produces a slow tick. Each channel counts consecutive

---
 rtl/hold_detect_multi.sv | 115 +++++++++++
 tb/tb_hold_detect_multi.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/hold_detect_multi.sv
// rtl/hold_detect_multi.sv - multi-channel hold detector with prescaler tick; HOLD_REPEAT_EN adds auto-repeat pulses
module hold_detect_multi #(
    parameter int CHANNELS     = 4,
    parameter int PRESCALE_W   = 14,
    parameter int HOLD_TICKS   = 12,
    parameter int REPEAT_TICKS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] ch_in,
    input  logic [CHANNELS-1:0] en_mask,
    output logic [CHANNELS-1:0] held,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] repeat_pulse,
    output logic                all_held,
    output logic                tick,
    output logic                slow_clk
);

    localparam int CNT_W = $clog2(HOLD_TICKS + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_TICKS);
    localparam logic [CNT_W-1:0] HOLD_PRE = CNT_W'(HOLD_TICKS - 1);

    if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
        $error("CHANNELS must be 1..8");
    end
    if (PRESCALE_W < 1 || HOLD_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_params
        $error("PRESCALE_W, HOLD_TICKS and REPEAT_TICKS must be >= 1");
    end

    logic [PRESCALE_W-1:0] p;
    logic [CHANNELS-1:0]   sync1;
    logic [CHANNELS-1:0]   s;
    logic [CNT_W-1:0]      cnt [CHANNELS];
    logic [CHANNELS-1:0]   press_q;

    assign tick     = &p;
    assign slow_clk = p[PRESCALE_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            p     <= '0;
            sync1 <= '0;
            s     <= '0;
        end else begin
            p     <= p + PRESCALE_W'(1);
            sync1 <= ch_in;
            s     <= sync1;
        end
    end

    // Disable clears at any edge; otherwise only the tick sample matters, so
    // input glitches between ticks never reach the counters.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (rst) begin
                cnt[i]     <= '0;
                press_q[i] <= 1'b0;
            end else begin
                press_q[i] <= tick & en_mask[i] & s[i] & (cnt[i] == HOLD_PRE);
                if (!en_mask[i]) begin
                    cnt[i] <= '0;
                end else if (tick) begin
                    if (!s[i]) begin
                        cnt[i] <= '0;
                    end else if (cnt[i] != HOLD_MAX) begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        held = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            held[i] = (cnt[i] == HOLD_MAX);
        end
    end

    assign press_pulse = press_q;
    assign all_held    = ((held & en_mask) == en_mask) && (en_mask != '0);

`ifdef HOLD_REPEAT_EN
    localparam int R_W = $clog2(REPEAT_TICKS + 1);
    localparam logic [R_W-1:0] REP_LAST = R_W'(REPEAT_TICKS - 1);

    logic [R_W-1:0]      r [CHANNELS];
    logic [CHANNELS-1:0] rep_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (rst || !held[i]) begin
                r[i]     <= '0;
                rep_q[i] <= 1'b0;
            end else if (tick && s[i]) begin
                if (r[i] == REP_LAST) begin
                    r[i]     <= '0;
                    rep_q[i] <= 1'b1;
                end else begin
                    r[i]     <= r[i] + R_W'(1);
                    rep_q[i] <= 1'b0;
                end
            end else begin
                rep_q[i] <= 1'b0;
            end
        end
    end

    assign repeat_pulse = rep_q;
`else
    assign repeat_pulse = '0;
`endif

endmodule

// File: tb/tb_hold_detect_multi.sv
// tb/tb_hold_detect_multi.sv - table-driven bench for hold_detect_multi (honours HOLD_REPEAT_EN)
module tb_hold_detect_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ch_in;
    logic [3:0] en_mask;
    logic [3:0] held;
    logic [3:0] press_pulse;
    logic [3:0] repeat_pulse;
    logic       all_held;
    logic       tick;
    logic       slow_clk;

    hold_detect_multi #(
        .CHANNELS    (4),
        .PRESCALE_W  (2),
        .HOLD_TICKS  (3),
        .REPEAT_TICKS(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ch_in       (ch_in),
        .en_mask     (en_mask),
        .held        (held),
        .press_pulse (press_pulse),
        .repeat_pulse(repeat_pulse),
        .all_held    (all_held),
        .tick        (tick),
        .slow_clk    (slow_clk)
    );

    always #5 clk = ~clk;

`ifdef HOLD_REPEAT_EN
    localparam logic [3:0] R1 = 4'b0001;
`else
    localparam logic [3:0] R1 = 4'b0000;
`endif

    typedef struct {
        int         cyc;
        logic       rst;
        logic [3:0] ch;
        logic [3:0] en;
        logic [3:0] held;
        logic [3:0] press;
        logic [3:0] rep;
        logic       all;
        logic       tick;
        logic       slow;
    } vec_t;

    vec_t vq[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input int cyc, input logic r, input logic [3:0] ch,
                                input logic [3:0] en, input logic [3:0] hl,
                                input logic [3:0] pr, input logic [3:0] rp,
                                input logic al, input logic tk, input logic sl);
        vec_t v;
        v.cyc = cyc; v.rst = r; v.ch = ch; v.en = en; v.held = hl;
        v.press = pr; v.rep = rp; v.all = al; v.tick = tk; v.slow = sl;
        return v;
    endfunction

    task automatic check(input string name, input int cyc, input logic [3:0] act,
                         input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%b expected=%b", name, cyc, act, exp);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        ch_in   = '0;
        en_mask = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Applies vq from a fresh reset; each record's inputs hold until the next record.
    task automatic run_queue(input string tag);
        int idx  = 0;
        int last = vq[vq.size()-1].cyc;
        do_reset();
        for (int c = 0; c <= last; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (idx < vq.size() && vq[idx].cyc == c) begin
                rst     = vq[idx].rst;
                ch_in   = vq[idx].ch;
                en_mask = vq[idx].en;
                @(negedge clk);
                check({tag, ".held"},  c, held,                vq[idx].held);
                check({tag, ".press"}, c, press_pulse,         vq[idx].press);
                check({tag, ".rep"},   c, repeat_pulse,        vq[idx].rep);
                check({tag, ".all"},   c, {3'b0, all_held},    {3'b0, vq[idx].all});
                check({tag, ".tick"},  c, {3'b0, tick},        {3'b0, vq[idx].tick});
                check({tag, ".slow"},  c, {3'b0, slow_clk},    {3'b0, vq[idx].slow});
                idx++;
            end
        end
        vq.delete();
    endtask

    initial begin
        // idle inputs: only the prescaler moves
        for (int c = 0; c <= 12; c++) begin
            vq.push_back(mk(c, 0, 4'b0000, 4'b1111, 4'b0, 4'b0, 4'b0, 0,
                            (c % 4) == 3, (c % 4) >= 2));
        end
        run_queue("t1_idle");

        // steady press on ch0, saturation and auto-repeat
        vq.push_back(mk( 0, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
        vq.push_back(mk(11, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 1, 1));
        vq.push_back(mk(12, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1, 0, 0));
        vq.push_back(mk(13, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1, 0, 0));
        vq.push_back(mk(19, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1, 1, 1));
        vq.push_back(mk(20, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, R1,      1, 0, 0));
        vq.push_back(mk(21, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1, 0, 0));
        vq.push_back(mk(27, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1, 1, 1));
        vq.push_back(mk(28, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, R1,      1, 0, 0));
        vq.push_back(mk(29, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1, 0, 0));
        run_queue("t2_hold");

        // release sampled at tick 15, then re-press from cycle 18
        vq.push_back(mk( 0, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
        vq.push_back(mk(12, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1, 0, 0));
        vq.push_back(mk(13, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1, 0, 0));
        vq.push_back(mk(15, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1, 1, 1));
        vq.push_back(mk(16, 0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
        vq.push_back(mk(18, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0, 1));
        vq.push_back(mk(31, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 1, 1));
        vq.push_back(mk(32, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1, 0, 0));
        run_queue("t3_release");

        // ch1 dips low for cycles 2..4, seen synchronised at 4..6, between ticks
        vq.push_back(mk( 0, 0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
        vq.push_back(mk( 2, 0, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 0, 1));
        vq.push_back(mk( 5, 0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
        vq.push_back(mk(11, 0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 1, 1));
        vq.push_back(mk(12, 0, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 1, 0, 0));
        run_queue("t4_glitch");

        // enable mask interaction with all_held and held
        vq.push_back(mk( 0, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
        vq.push_back(mk(12, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1, 0, 0));
        vq.push_back(mk(13, 0, 4'b0001, 4'b0011, 4'b0001, 4'b0000, 4'b0000, 0, 0, 0));
        vq.push_back(mk(14, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1, 0, 1));
        vq.push_back(mk(15, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 0, 1, 1));
        vq.push_back(mk(16, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
        run_queue("t5_enable");

        // reset mid-hold clears everything; counting restarts from the new cycle 0 (23)
        vq.push_back(mk( 0, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
        vq.push_back(mk(20, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, R1,      1, 0, 0));
        vq.push_back(mk(22, 1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1, 0, 1));
        vq.push_back(mk(23, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
        vq.push_back(mk(24, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
        vq.push_back(mk(26, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 1, 1));
        vq.push_back(mk(35, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1, 0, 0));
        run_queue("t6_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
